// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: access-control encoding, FSM states, data width.
package mem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte enables/replicated data, load extract/extend, error detect.
// Misalignment errors are raised only when DMEM_MISALIGN_CHECK_EN is defined.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      ctrl,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] rdata,
    output logic            err
);

    logic            illegal;
    logic            misalign;
    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;

    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        case (mem_ctrl_e'(ctrl))
            MEM_B, MEM_H, MEM_W: illegal = 1'b0;
            MEM_BU, MEM_HU:      illegal = we;
            default:             illegal = 1'b1;
        endcase
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = ((ctrl == MEM_H || ctrl == MEM_HU) && addr_lo[0]) ||
                   (ctrl == MEM_W && addr_lo != 2'b00);
`endif
        err = illegal | misalign;

        byte_sh = rword >> {addr_lo, 3'b000};
        half_sh = rword >> {addr_lo[1], 4'b0000};

        be       = 4'b0000;
        wdata_sh = wdata;
        rdata    = '0;
        if (!err) begin
            case (mem_ctrl_e'(ctrl))
                MEM_B: begin
                    be       = 4'b0001 << addr_lo;
                    wdata_sh = {4{wdata[7:0]}};
                    rdata    = {{24{byte_sh[7]}}, byte_sh[7:0]};
                end
                MEM_BU: rdata = {24'h0, byte_sh[7:0]};
                MEM_H: begin
                    be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_sh = {2{wdata[15:0]}};
                    rdata    = {{16{half_sh[15]}}, half_sh[15:0]};
                end
                MEM_HU: rdata = {16'h0, half_sh[15:0]};
                MEM_W: begin
                    be    = 4'b1111;
                    rdata = rword;
                end
                default: rdata = '0;
            endcase
        end
        // Stores never return data; loads never write.
        if (we) rdata = '0;
        else    be    = 4'b0000;
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory slave: one outstanding request, WAIT_CYCLES wait states, word RAM.
// Optional misalignment errors via DMEM_MISALIGN_CHECK_EN (see mem_lane_align).
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_ctrl,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [1:0]      dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] LAST_CNT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lat_we_q, lat_we_d;
    logic [ADDR_W+1:0] lat_addr_q, lat_addr_d;
    logic [XLEN-1:0]   lat_wdata_q, lat_wdata_d;
    logic [2:0]        lat_ctrl_q, lat_ctrl_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [XLEN-1:0]   mem_q [DEPTH];

    logic              acc_we;
    logic [ADDR_W+1:0] acc_addr;
    logic [XLEN-1:0]   acc_wdata;
    logic [2:0]        acc_ctrl;
    logic              do_acc;
    logic              mem_we;
    logic [3:0]        la_be;
    logic [XLEN-1:0]   la_wdata;
    logic [XLEN-1:0]   la_rdata;
    logic              la_err;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W+2];

    // With zero wait states the access is made straight from the incoming request.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr[ADDR_W+1:0];
            acc_wdata = req_wdata;
            acc_ctrl  = req_ctrl;
        end else begin
            acc_we    = lat_we_q;
            acc_addr  = lat_addr_q;
            acc_wdata = lat_wdata_q;
            acc_ctrl  = lat_ctrl_q;
        end
    end

    mem_lane_align u_align (
        .we       (acc_we),
        .ctrl     (acc_ctrl),
        .addr_lo  (acc_addr[1:0]),
        .wdata    (acc_wdata),
        .rword    (mem_q[acc_addr[ADDR_W+1:2]]),
        .be       (la_be),
        .wdata_sh (la_wdata),
        .rdata    (la_rdata),
        .err      (la_err)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        lat_ctrl_d   = lat_ctrl_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        do_acc       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lat_we_d    = req_we;
                    lat_addr_d  = req_addr[ADDR_W+1:0];
                    lat_wdata_d = req_wdata;
                    lat_ctrl_d  = req_ctrl;
                    cnt_d       = '0;
                    if (WAIT_CYCLES == 0) begin
                        do_acc  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    do_acc  = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_acc) begin
            resp_rdata_d = la_rdata;
            resp_err_d   = la_err;
        end
        mem_we       = do_acc & acc_we & ~la_err;
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            lat_ctrl_q   <= 3'b000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            lat_ctrl_q   <= lat_ctrl_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (la_be[b]) mem_q[acc_addr[ADDR_W+1:2]][8*b +: 8] <= la_wdata[8*b +: 8];
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign dbg_state  = state_q;

endmodule
